// File: rtl/pic_pkg.sv
// Shared constants, region id encoding and colour expansion for the picture
// region scheduler.
package pic_pkg;

  localparam int PIC_W = 128;
  localparam int PIC_H = 64;
  localparam int N_REG = 3;

  typedef enum logic [1:0] {
    REG_HORA  = 2'd0,
    REG_FECHA = 2'd1,
    REG_TIMER = 2'd2
  } region_id_e;

  typedef logic [11:0] rgb444_t;

  // Each RGB332 field lands in the top bits of its 4-bit channel.
  function automatic rgb444_t rgb332_to_444(input logic [7:0] d);
    return {d[7:5], 1'b0, d[4:2], 1'b0, d[1:0], 2'b00};
  endfunction

endpackage

// File: rtl/pic_region_sched_if.sv
// Shared picture ROM port plus the registered pixel outputs of the scheduler.
interface pic_region_sched_if #(
  parameter int ROM_AW = 15
);

  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              pic_on;
  logic [11:0]       pic_RGB;

  modport master (
    output rom_addr,
    output pic_on,
    output pic_RGB,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  pic_on,
    input  pic_RGB,
    output rom_data
  );

endinterface

// File: rtl/pic_blink_timer.sv
// Frame-based blink phase generator; only instantiated when PIC_BLINK_EN is
// defined. blink_off is high during the OFF half-period.
module pic_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] sel_field,
  output logic       blink_off
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       off_q, off_d;
  logic [1:0] sel_q, sel_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    off_d = off_q;
    sel_d = sel_field;
    // A new selection restarts the blink in the ON phase, even on a tick.
    if (sel_field != sel_q) begin
      cnt_d = '0;
      off_d = 1'b0;
    end else if (frame_tick) begin
      if (cnt_q == LAST_FRAME) begin
        cnt_d = '0;
        off_d = ~off_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      off_q <= 1'b0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      off_q <= off_d;
      sel_q <= sel_d;
    end
  end

  assign blink_off = off_q;

endmodule

// File: rtl/pic_region_sched.sv
// Region decode and 3-stage shared-ROM pipeline for the hora/fecha/timer pictures.
// Build option: define PIC_BLINK_EN to blink the region chosen by sel_field.
module pic_region_sched
  import pic_pkg::*;
#(
  parameter int BLINK_FRAMES = 30,
  parameter int ROM_AW       = 15,
  parameter int XL0          = 256,
  parameter int YT0          = 0,
  parameter int XL1          = 256,
  parameter int YT1          = 96,
  parameter int XL2          = 256,
  parameter int YT2          = 192
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      video_on,
  input  logic [9:0]                pixel_x,
  input  logic [9:0]                pixel_y,
  input  logic                      frame_tick,
  input  logic [2:0]                region_en,
  input  logic [1:0]                sel_field,
  pic_region_sched_if.master        bus
);

  localparam logic [9:0] XL [N_REG] = '{10'(XL0), 10'(XL1), 10'(XL2)};
  localparam logic [9:0] YT [N_REG] = '{10'(YT0), 10'(YT1), 10'(YT2)};

  logic              hit_w;
  region_id_e        id_w;
  logic [9:0]        dx_w, dy_w;
  logic [6:0]        col_w;
  logic [5:0]        row_w;

  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              hit1_q, hit1_d;
  region_id_e        id1_q, id1_d;
  logic              hit2_q, hit2_d;
  region_id_e        id2_q, id2_d;
  logic              pic_on_q, pic_on_d;
  rgb444_t           pic_rgb_q, pic_rgb_d;
  logic              blank_w;

  // Scanning from the highest index down lets the lowest hit index win.
  always_comb begin
    hit_w = 1'b0;
    id_w  = REG_HORA;
    col_w = '0;
    row_w = '0;
    dx_w  = '0;
    dy_w  = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      dx_w = pixel_x - XL[i];
      dy_w = pixel_y - YT[i];
      if (video_on && region_en[i] &&
          (pixel_x >= XL[i]) && (pixel_y >= YT[i]) &&
          (dx_w < 10'(PIC_W)) && (dy_w < 10'(PIC_H))) begin
        hit_w = 1'b1;
        id_w  = region_id_e'(i[1:0]);
        col_w = dx_w[6:0];
        row_w = dy_w[5:0];
      end
    end
  end

`ifdef PIC_BLINK_EN
  logic blink_off;

  pic_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .sel_field (sel_field),
    .blink_off (blink_off)
  );

  assign blank_w = blink_off && (sel_field == (2'(id2_q) + 2'd1));
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_blink;
  assign unused_blink = ^{frame_tick, sel_field, id2_q};
  assign blank_w      = 1'b0;
`endif

  // The address is left untouched on a miss so the ROM sees no spurious change.
  always_comb begin
    rom_addr_d = hit_w ? ROM_AW'({id_w, row_w, col_w}) : rom_addr_q;
    hit1_d     = hit_w;
    id1_d      = id_w;
    hit2_d     = hit1_q;
    id2_d      = id1_q;
    pic_on_d   = 1'b0;
    pic_rgb_d  = '0;
    if (hit2_q) begin
      pic_on_d  = 1'b1;
      pic_rgb_d = blank_w ? rgb444_t'(0) : rgb332_to_444(bus.rom_data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      id1_q      <= REG_HORA;
      hit2_q     <= 1'b0;
      id2_q      <= REG_HORA;
      pic_on_q   <= 1'b0;
      pic_rgb_q  <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit1_d;
      id1_q      <= id1_d;
      hit2_q     <= hit2_d;
      id2_q      <= id2_d;
      pic_on_q   <= pic_on_d;
      pic_rgb_q  <= pic_rgb_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.pic_on   = pic_on_q;
  assign bus.pic_RGB  = pic_rgb_q;

endmodule

// File: tb/tb_pic_region_sched.sv
// Scoreboard bench for pic_region_sched: stimulus queues expected ROM address
// (T+1) and pixel (T+3); a negedge monitor pops and compares.
module tb_pic_region_sched;

  logic       clk;
  logic       reset;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_tick;
  logic [2:0] region_en;
  logic [1:0] sel_field;

  pic_region_sched_if #(.ROM_AW(15)) bus ();

  pic_region_sched dut (
    .clk       (clk),
    .reset     (reset),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .frame_tick(frame_tick),
    .region_en (region_en),
    .sel_field (sel_field),
    .bus       (bus)
  );

  typedef struct {
    int unsigned cyc;
    logic [14:0] addr;
    logic        on;
    logic [11:0] rgb;
    string       name;
  } exp_t;

  exp_t        addr_q[$];
  exp_t        pix_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: data is a fixed function of the address, one clock late.
  always @(posedge clk) bus.rom_data <= bus.rom_addr[7:0] ^ 8'hCF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (addr_q.size() != 0 && addr_q[0].cyc + 1 <= cyc) begin
      check({"addr_", addr_q[0].name}, 32'(bus.rom_addr), 32'(addr_q[0].addr));
      void'(addr_q.pop_front());
    end
    if (pix_q.size() != 0 && pix_q[0].cyc + 3 <= cyc) begin
      check({"pix_", pix_q[0].name}, {19'd0, bus.pic_on, bus.pic_RGB},
            {19'd0, pix_q[0].on, pix_q[0].rgb});
      void'(pix_q.pop_front());
    end
  end

  task automatic apply(input string name, input logic [9:0] x, input logic [9:0] y,
                       input logic vo, input logic [2:0] en, input logic [14:0] ea,
                       input logic eon, input logic [11:0] ergb);
    exp_t e;
    pixel_x   = x;
    pixel_y   = y;
    video_on  = vo;
    region_en = en;
    e.cyc  = cyc;
    e.addr = ea;
    e.on   = eon;
    e.rgb  = ergb;
    e.name = name;
    addr_q.push_back(e);
    pix_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    video_on = 1'b0;
    pixel_x  = '0;
    pixel_y  = '0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (addr_q.size() + pix_q.size()) != 0; i++) @(negedge clk);
    check("drain_addr", 32'(addr_q.size()), 32'd0);
    check("drain_pix", 32'(pix_q.size()), 32'd0);
    addr_q.delete();
    pix_q.delete();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    video_on   = 1'b0;
    pixel_x    = '0;
    pixel_y    = '0;
    frame_tick = 1'b0;
    region_en  = 3'b111;
    sel_field  = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_addr", 32'(bus.rom_addr), 32'd0);
    check("reset_on", 32'(bus.pic_on), 32'd0);
    check("reset_rgb", 32'(bus.pic_RGB), 32'd0);
    reset = 1'b0;

    // ROM data = addr[7:0] ^ 0xCF; colours expanded by hand.
    apply("hora_300_10",   10'd300, 10'd10,  1'b1, 3'b111, 15'h052C, 1'b1, 12'hE0C);
    apply("fecha_300_100", 10'd300, 10'd100, 1'b1, 3'b111, 15'h222C, 1'b1, 12'hE0C);
    apply("miss_x255",     10'd255, 10'd10,  1'b1, 3'b111, 15'h222C, 1'b0, 12'h000);
    apply("fecha_corner",  10'd383, 10'd159, 1'b1, 3'b111, 15'h3FFF, 1'b1, 12'h280);
    apply("miss_x384",     10'd384, 10'd10,  1'b1, 3'b111, 15'h3FFF, 1'b0, 12'h000);
    apply("hora_origin",   10'd256, 10'd0,   1'b1, 3'b111, 15'h0000, 1'b1, 12'hC6C);
    apply("miss_y64",      10'd256, 10'd64,  1'b1, 3'b111, 15'h0000, 1'b0, 12'h000);
    apply("timer_260_200", 10'd260, 10'd200, 1'b1, 3'b111, 15'h4404, 1'b1, 12'hC4C);
    apply("hora_disabled", 10'd300, 10'd10,  1'b1, 3'b110, 15'h4404, 1'b0, 12'h000);
    apply("video_off",     10'd260, 10'd200, 1'b0, 3'b111, 15'h4404, 1'b0, 12'h000);
    idle();
    drain();

`ifdef PIC_BLINK_EN
    sel_field = 2'd1;
    @(negedge clk);
    ticks(30);
    apply("blink_off_hora",  10'd300, 10'd10,  1'b1, 3'b111, 15'h052C, 1'b1, 12'h000);
    apply("blink_off_fecha", 10'd300, 10'd100, 1'b1, 3'b111, 15'h222C, 1'b1, 12'hE0C);
    idle();
    drain();
    ticks(30);
    apply("blink_on_hora",   10'd300, 10'd10,  1'b1, 3'b111, 15'h052C, 1'b1, 12'hE0C);
    idle();
    drain();
    ticks(30);
    ticks(5);
    sel_field  = 2'd2;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    apply("sel_change_on",   10'd300, 10'd100, 1'b1, 3'b111, 15'h222C, 1'b1, 12'hE0C);
    idle();
    drain();
    ticks(29);
    apply("no_early_toggle", 10'd300, 10'd100, 1'b1, 3'b111, 15'h222C, 1'b1, 12'hE0C);
    idle();
    drain();
    ticks(1);
    apply("fecha_off",       10'd300, 10'd100, 1'b1, 3'b111, 15'h222C, 1'b1, 12'h000);
    idle();
    drain();
    sel_field = 2'd0;
    @(negedge clk);
`endif

    // Fill all stages, then reset for a single clock.
    pixel_x   = 10'd300;
    pixel_y   = 10'd10;
    region_en = 3'b111;
    video_on  = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_on", 32'(bus.pic_on), 32'd1);
    reset    = 1'b1;
    video_on = 1'b0;
    @(negedge clk);
    check("mid_reset_addr", 32'(bus.rom_addr), 32'd0);
    check("mid_reset_on", 32'(bus.pic_on), 32'd0);
    check("mid_reset_rgb", 32'(bus.pic_RGB), 32'd0);
    reset = 1'b0;
    apply("after_reset", 10'd256, 10'd0, 1'b1, 3'b111, 15'h0000, 1'b1, 12'hC6C);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
